axis_fifo_mon: RTL and testbench

- Synchronous AXI4-Stream FIFO, the next generation of the team's stream FIFO.
- Adds live occupancy and frame-count reporting, runtime-programmable almost-full/almost-empty thresholds, and a synchronous flush.
- Optional high-watermark tracking.
- Sits between stream producers/consumers (e.g. I2C master command/data paths) where firmware must poll fill level.

---
 rtl/axis_fifo_mon.sv | 102 ++++++++++
 tb/tb_axis_fifo_mon.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_mon.sv
// axis_fifo_mon: AXI4-Stream FIFO with occupancy/frame status, programmable thresholds and flush.
// Define AXIS_FIFO_MON_WATERMARK_EN to enable peak-depth tracking on status_watermark.
module axis_fifo_mon #(
  parameter int DEPTH       = 1024,
  parameter int DATA_WIDTH  = 8,
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1,
  parameter int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [ADDR_WIDTH:0]   cfg_af_thresh,
  input  logic [ADDR_WIDTH:0]   cfg_ae_thresh,
  output logic [ADDR_WIDTH:0]   status_depth,
  output logic [ADDR_WIDTH:0]   status_frames,
  output logic                  status_full,
  output logic                  status_empty,
  output logic                  status_almost_full,
  output logic                  status_almost_empty,
  output logic [ADDR_WIDTH:0]   status_watermark
);
  localparam int W  = USER_WIDTH + 1 + DATA_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;

  logic [W-1:0]          mem [2**ADDR_WIDTH];
  logic [PW-1:0]         wr_ptr, rd_ptr, wr_nxt, rd_nxt, frames;
  logic                  wr_en, rd_en, word_last, frame_in;
  logic [W-1:0]          rd_word;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [USER_WIDTH-1:0] out_user;

  assign status_full   = (wr_ptr ^ rd_ptr) == {1'b1, {ADDR_WIDTH{1'b0}}};
  assign status_empty  = wr_ptr == rd_ptr;
  assign status_depth  = wr_ptr - rd_ptr;
  assign status_frames = frames;
  assign status_almost_full  = status_depth >= cfg_af_thresh;
  assign status_almost_empty = status_depth <= cfg_ae_thresh;

  assign s_axis_tready = !status_full && !flush;
  assign wr_en   = s_axis_tvalid && s_axis_tready;
  assign rd_en   = (m_axis_tready || !m_axis_tvalid) && !status_empty && !flush;
  assign wr_nxt  = wr_ptr + PW'(wr_en);
  assign rd_nxt  = rd_ptr + PW'(rd_en);
  assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Without tlast propagation every word is its own frame.
  assign word_last = (LAST_ENABLE == 0) || rd_word[DATA_WIDTH];
  assign frame_in  = (LAST_ENABLE == 0) || s_axis_tlast;

  assign m_axis_tdata = out_data;
  assign m_axis_tlast = (LAST_ENABLE == 0) ? 1'b1 : out_last;
  assign m_axis_tuser = (USER_ENABLE == 0) ? '0 : out_user;

  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};

  always_ff @(posedge clk)
    if (rd_en) {out_user, out_last, out_data} <= rd_word;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      frames        <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      frames        <= '0;
      m_axis_tvalid <= 1'b0;
    end else begin
      wr_ptr        <= wr_nxt;
      rd_ptr        <= rd_nxt;
      frames        <= frames + PW'(wr_en && frame_in) - PW'(rd_en && word_last);
      m_axis_tvalid <= rd_en ? 1'b1 : (m_axis_tready ? 1'b0 : m_axis_tvalid);
    end

`ifdef AXIS_FIFO_MON_WATERMARK_EN
  logic [PW-1:0] wmark, depth_nxt;
  assign depth_nxt        = wr_nxt - rd_nxt;
  assign status_watermark = wmark;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wmark <= '0;
    else if (flush) wmark <= '0;
    else if (depth_nxt > wmark) wmark <= depth_nxt;
`else
  assign status_watermark = '0;
`endif
endmodule

// File: tb/tb_axis_fifo_mon.sv
// tb_axis_fifo_mon: directed bench for axis_fifo_mon (DEPTH=16) against a queue-based model.
module tb_axis_fifo_mon;
  logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic [7:0] s_axis_tdata = '0, m_axis_tdata;
  logic       s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [0:0] s_axis_tuser = '0, m_axis_tuser;
  logic       m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast;
  logic [4:0] cfg_af_thresh = 5'd12, cfg_ae_thresh = 5'd3;
  logic [4:0] status_depth, status_frames, status_watermark;
  logic       status_full, status_empty, status_almost_full, status_almost_empty;

  int  vec = 0, err = 0;
  bit  en = 1'b0;
  logic [9:0] q[$];
  logic [9:0] mw;
  bit  mv = 1'b0;
  int  wm = 0;

  axis_fifo_mon #(.DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .cfg_af_thresh(cfg_af_thresh), .cfg_ae_thresh(cfg_ae_thresh),
    .status_depth(status_depth), .status_frames(status_frames),
    .status_full(status_full), .status_empty(status_empty),
    .status_almost_full(status_almost_full), .status_almost_empty(status_almost_empty),
    .status_watermark(status_watermark)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction

  function automatic int frames_q();
    int c = 0;
    foreach (q[i]) c += int'(q[i][8]);
    return c;
  endfunction

  // RAM is a queue; the output register is (mv, mw).
  task automatic model_edge();
    bit acc;
    if (flush) begin
      q.delete(); mv = 1'b0; wm = 0;
    end else begin
      acc = s_axis_tvalid && q.size() < 16;
      if (m_axis_tready || !mv) begin
        if (q.size() > 0) begin mw = q.pop_front(); mv = 1'b1; end
        else mv = 1'b0;
      end
      if (acc) q.push_back({s_axis_tuser, s_axis_tlast, s_axis_tdata});
      if (q.size() > wm) wm = q.size();
    end
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r, input bit f);
    s_axis_tvalid = v; s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = d[0];
    m_axis_tready = r; flush = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) if (en) begin
    chk("tready", s_axis_tready, !flush && q.size() < 16);
    chk("tvalid", m_axis_tvalid, mv);
    if (mv) begin
      chk("tdata", m_axis_tdata, mw[7:0]);
      chk("tlast", m_axis_tlast, mw[8]);
      chk("tuser", m_axis_tuser, mw[9]);
    end
    chk("depth", status_depth, q.size());
    chk("frames", status_frames, frames_q());
    chk("full", status_full, q.size() == 16);
    chk("empty", status_empty, q.size() == 0);
    chk("almost_full", status_almost_full, q.size() >= int'(cfg_af_thresh));
    chk("almost_empty", status_almost_empty, q.size() <= int'(cfg_ae_thresh));
`ifdef AXIS_FIFO_MON_WATERMARK_EN
    chk("watermark", status_watermark, wm);
`else
    chk("watermark", status_watermark, 0);
`endif
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n, cnt;
    bit acc;
    @(negedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    chk("rst_depth", status_depth, 0);
    chk("rst_empty", status_empty, 1);
    chk("rst_full", status_full, 0);
    chk("rst_tready", s_axis_tready, 1);
    chk("rst_ae", status_almost_empty, 1);
    chk("rst_af", status_almost_full, 0);

    // Fill 16 RAM words plus the output register
    for (int i = 0; i < 17; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 11) chk("af_at_11", status_almost_full, 0);
      if (i == 12) chk("af_at_12", status_almost_full, 1);
    end
    chk("fill_depth", status_depth, 16);
    chk("fill_full", status_full, 1);
    chk("fill_tready", s_axis_tready, 0);
    chk("fill_head", m_axis_tdata, 0);
    step(1, 8'hEE, 0, 0, 0);
    chk("refused_depth", status_depth, 16);
    for (int i = 0; i < 17; i++) begin
      chk("drain_data", m_axis_tdata, i);
      chk("drain_depth", status_depth, 16 - i);
      chk("drain_ae", status_almost_empty, (16 - i) <= 3);
      step(0, 0, 0, 1, 0);
    end
    chk("drained_tvalid", m_axis_tvalid, 0);

    // Three 4-word frames
    for (int i = 0; i < 12; i++) step(1, 8'(8'h10 + i), (i % 4) == 3, 0, 0);
    chk("frames_3", status_frames, 3);
    chk("frames_depth", status_depth, 11);
    for (int k = 0; k < 40 && (m_axis_tvalid || !status_empty); k++) step(0, 0, 0, 1, 0);
    chk("frames_0", status_frames, 0);
    chk("frames_drained", m_axis_tvalid, 0);

    // Flush with a concurrent write
    for (int i = 0; i < 10; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
    chk("pre_flush_depth", status_depth, 9);
    step(1, 8'h77, 1, 0, 1);
    chk("flush_depth", status_depth, 0);
    chk("flush_frames", status_frames, 0);
    chk("flush_tvalid", m_axis_tvalid, 0);
`ifdef AXIS_FIFO_MON_WATERMARK_EN
    chk("flush_wm", status_watermark, 0);
`endif
    step(0, 0, 0, 0, 0);
    chk("post_flush_depth", status_depth, 0);

    // Single-word latency
    step(1, 8'hA5, 1, 1, 0);
    chk("lat_n_depth", status_depth, 1);
    chk("lat_n_tvalid", m_axis_tvalid, 0);
    step(0, 0, 0, 1, 0);
    chk("lat_n1_tvalid", m_axis_tvalid, 1);
    chk("lat_n1_tdata", m_axis_tdata, 8'hA5);
    chk("lat_n1_depth", status_depth, 0);
    step(0, 0, 0, 1, 0);
    chk("lat_gone", m_axis_tvalid, 0);

    // Continuous traffic with random backpressure, wraps the pointers
    n = 0; cnt = 0;
    while (n < 40 && cnt < 400) begin
      acc = q.size() < 16;
      step(1, 8'(8'h40 + n), (n % 5) == 4, 1'($urandom_range(0, 1)), 0);
      if (acc) n++;
      cnt++;
    end
    chk("rand_accepted", n, 40);
    s_axis_tvalid = 1'b0;
    for (int k = 0; k < 60 && (m_axis_tvalid || !status_empty); k++) step(0, 0, 0, 1, 0);
    chk("rand_drained", m_axis_tvalid, 0);

    // Reset mid-frame
    for (int i = 0; i < 3; i++) step(1, 8'(i), 0, 0, 0);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0; q.delete(); mv = 1'b0; wm = 0;
    #1;
    chk("midrst_depth", status_depth, 0);
    chk("midrst_tvalid", m_axis_tvalid, 0);
    chk("midrst_frames", status_frames, 0);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("post_rst_empty", status_empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
